tdm_demux_rx: RTL and testbench

//  Receive end of a time-division multiplexed link: one shared DATA_W-bit lane

---
 rtl/tdm_demux_rx_if.sv | 24 ++
 rtl/tdm_demux_rx.sv | 103 ++++++++++
 tb/tb_tdm_demux_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_rx_if.sv
// Bundles the TDM lane inputs and the demultiplexed frame outputs.
// master: the side that drives the lane. slave: the receiver.
interface tdm_demux_rx_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
);
   logic                     din_valid;
   logic                     frame_sync;
   logic [DATA_W-1:0]        din;
   logic [NUM_CH*DATA_W-1:0] ch_out;
   logic                     frame_done;
   logic                     sync_err;
   logic                     locked;

   modport master (
      output din_valid, frame_sync, din,
      input  ch_out, frame_done, sync_err, locked
   );

   modport slave (
      input  din_valid, frame_sync, din,
      output ch_out, frame_done, sync_err, locked
   );
endinterface

// File: rtl/tdm_demux_rx.sv
// TDM receiver: locks onto frame_sync, gathers NUM_CH samples into shadow
// registers and publishes each complete frame atomically on ch_out.
module tdm_demux_rx #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   tdm_demux_rx_if.slave  bus
);
   localparam int SLOT_W = $clog2(NUM_CH);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t                   state_q, state_d;
   logic [SLOT_W-1:0]        slot_q, slot_d;
   logic [DATA_W-1:0]        shadow_q [NUM_CH];
   logic [DATA_W-1:0]        shadow_d [NUM_CH];
   logic [NUM_CH*DATA_W-1:0] ch_out_q, ch_out_d;
   logic                     frame_done_q, frame_done_d;
   logic                     sync_err_q, sync_err_d;
   logic                     locked_q, locked_d;
   logic [NUM_CH*DATA_W-1:0] frame_next;

   // Completed frame: buffered slots plus the last sample arriving this cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH - 1; gi++) begin : g_frame
         assign frame_next[gi*DATA_W +: DATA_W] = shadow_q[gi];
      end
   endgenerate
   assign frame_next[(NUM_CH-1)*DATA_W +: DATA_W] = bus.din;

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      shadow_d     = shadow_q;
      ch_out_d     = ch_out_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;

      if (bus.din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (bus.frame_sync) begin
                  shadow_d[0] = bus.din;
                  slot_d      = SLOT_W'(1);
                  state_d     = LOCK;
               end
            end
            LOCK: begin
               if (bus.frame_sync) begin
                  // Early sync restarts the frame; the published frame stays.
                  sync_err_d  = (slot_q != '0);
                  shadow_d[0] = bus.din;
                  slot_d      = SLOT_W'(1);
               end else if (slot_q == '0) begin
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
               end else begin
                  shadow_d[slot_q] = bus.din;
                  if (slot_q == LAST_SLOT) begin
                     slot_d       = '0;
                     ch_out_d     = frame_next;
                     frame_done_d = 1'b1;
                  end else begin
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d = (state_d == LOCK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HUNT;
         slot_q       <= '0;
         ch_out_q     <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         locked_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         ch_out_q     <= ch_out_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         locked_q     <= locked_d;
         shadow_q     <= shadow_d;
      end
   end

   assign bus.ch_out     = ch_out_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.locked     = locked_q;
endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (NUM_CH=4, DATA_W=8): a vector table for
// framing behaviour plus hand-written async-reset sequences.
module tb_tdm_demux_rx;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int NVEC   = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;

   tdm_demux_rx_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   tdm_demux_rx #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic [31:0] ch;
      logic        fd;
      logic        se;
      logic        lk;
   } vec_t;

   vec_t tbl [NVEC];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(logic v, logic s, logic [7:0] d,
                               logic [31:0] ch, logic fd, logic se, logic lk);
      vec_t r;
      r.v = v; r.s = s; r.d = d; r.ch = ch; r.fd = fd; r.se = se; r.lk = lk;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [31:0] ch, logic fd, logic se, logic lk);
      chk({tag, ".ch_out"},     bus.ch_out,            ch);
      chk({tag, ".frame_done"}, {31'b0, bus.frame_done}, {31'b0, fd});
      chk({tag, ".sync_err"},   {31'b0, bus.sync_err},   {31'b0, se});
      chk({tag, ".locked"},     {31'b0, bus.locked},     {31'b0, lk});
   endtask

   // Drive one cycle of lane input, then sample just after the clock edge.
   task automatic step(logic v, logic s, logic [7:0] d);
      bus.din_valid  = v;
      bus.frame_sync = s;
      bus.din        = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Nominal frame, then the same shape with gaps
      tbl[0]  = mk(1, 1, 8'hAA, 32'h0,        0, 0, 1);
      tbl[1]  = mk(1, 0, 8'h11, 32'h0,        0, 0, 1);
      tbl[2]  = mk(1, 0, 8'h22, 32'h0,        0, 0, 1);
      tbl[3]  = mk(1, 0, 8'h33, 32'h332211AA, 1, 0, 1);
      tbl[4]  = mk(0, 0, 8'h00, 32'h332211AA, 0, 0, 1);
      tbl[5]  = mk(1, 1, 8'h5A, 32'h332211AA, 0, 0, 1);
      tbl[6]  = mk(0, 1, 8'hFF, 32'h332211AA, 0, 0, 1);
      tbl[7]  = mk(1, 0, 8'h6B, 32'h332211AA, 0, 0, 1);
      tbl[8]  = mk(0, 0, 8'h00, 32'h332211AA, 0, 0, 1);
      tbl[9]  = mk(1, 0, 8'h7C, 32'h332211AA, 0, 0, 1);
      tbl[10] = mk(0, 0, 8'h00, 32'h332211AA, 0, 0, 1);
      tbl[11] = mk(1, 0, 8'h8D, 32'h8D7C6B5A, 1, 0, 1);
      tbl[12] = mk(0, 0, 8'h00, 32'h8D7C6B5A, 0, 0, 1);
      // Early sync
      tbl[13] = mk(1, 1, 8'h01, 32'h8D7C6B5A, 0, 0, 1);
      tbl[14] = mk(1, 0, 8'h02, 32'h8D7C6B5A, 0, 0, 1);
      tbl[15] = mk(1, 1, 8'hA0, 32'h8D7C6B5A, 0, 1, 1);
      tbl[16] = mk(1, 0, 8'hB0, 32'h8D7C6B5A, 0, 0, 1);
      tbl[17] = mk(1, 0, 8'hC0, 32'h8D7C6B5A, 0, 0, 1);
      tbl[18] = mk(1, 0, 8'hD0, 32'hD0C0B0A0, 1, 0, 1);
      // Missing sync, ignored samples in HUNT, relock
      tbl[19] = mk(1, 0, 8'h55, 32'hD0C0B0A0, 0, 1, 0);
      tbl[20] = mk(1, 0, 8'h66, 32'hD0C0B0A0, 0, 0, 0);
      tbl[21] = mk(1, 0, 8'h77, 32'hD0C0B0A0, 0, 0, 0);
      tbl[22] = mk(1, 1, 8'hE1, 32'hD0C0B0A0, 0, 0, 1);
      tbl[23] = mk(1, 0, 8'hE2, 32'hD0C0B0A0, 0, 0, 1);
      tbl[24] = mk(1, 0, 8'hE3, 32'hD0C0B0A0, 0, 0, 1);
      tbl[25] = mk(1, 0, 8'hE4, 32'hE4E3E2E1, 1, 0, 1);

      bus.din_valid  = 1'b0;
      bus.frame_sync = 1'b0;
      bus.din        = '0;

      // Reset state while held
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset_hold", 32'h0, 0, 0, 0);
      $display("reset_hold ch_out=%h fd=%b se=%b lk=%b",
               bus.ch_out, bus.frame_done, bus.sync_err, bus.locked);
      #2 rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].d);
         $display("vec %0d v=%b s=%b din=%h ch_out=%h fd=%b se=%b lk=%b",
                  i, tbl[i].v, tbl[i].s, tbl[i].d,
                  bus.ch_out, bus.frame_done, bus.sync_err, bus.locked);
         chk_all($sformatf("vec%0d", i), tbl[i].ch, tbl[i].fd, tbl[i].se, tbl[i].lk);
      end

      // Async reset mid-run: outputs clear before any clock edge
      step(1, 1, 8'h41);
      step(1, 0, 8'h42);
      step(1, 0, 8'h43);
      step(1, 0, 8'h44);
      chk_all("pre_async", 32'h44434241, 1, 0, 1);
      #2 rst = 1'b1;
      #1;
      $display("async_rst ch_out=%h fd=%b se=%b lk=%b",
               bus.ch_out, bus.frame_done, bus.sync_err, bus.locked);
      chk_all("async_rst", 32'h0, 0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-frame: partial frame discarded, new frame published cleanly
      step(1, 1, 8'h11);
      step(1, 0, 8'h22);
      chk_all("mid_frame", 32'h0, 0, 0, 1);
      #2 rst = 1'b1;
      #1;
      chk_all("mid_rst", 32'h0, 0, 0, 0);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      // Unsynced sample after reset must be dropped (still hunting)
      step(1, 0, 8'h33);
      chk_all("post_rst_hunt", 32'h0, 0, 0, 0);
      step(1, 1, 8'h91);
      step(1, 0, 8'h92);
      step(1, 0, 8'h93);
      chk_all("new_frame_partial", 32'h0, 0, 0, 1);
      step(1, 0, 8'h94);
      $display("new_frame ch_out=%h fd=%b se=%b lk=%b",
               bus.ch_out, bus.frame_done, bus.sync_err, bus.locked);
      chk_all("new_frame", 32'h94939291, 1, 0, 1);
      step(0, 0, 8'h00);
      chk_all("new_frame_hold", 32'h94939291, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
